// File: rtl/acc_control_sequencer_if.sv
// Handshake, ALU-flag and datapath-control bundle for acc_control_sequencer.
// The slave side is the sequencer; the master side issues opcodes and
// supplies the ALU flags.
interface acc_control_sequencer_if #(
   parameter int unsigned OPCODE_W = 3
);
   logic                instr_valid;
   logic                instr_ready;
   logic [OPCODE_W-1:0] opcode;
   logic                alu_cf;
   logic                alu_zf;
   logic                nla;
   logic                nlb;
   logic                ea;
   logic                eu;
   logic                sub;
   logic                out_strobe;
   logic                cf;
   logic                zf;
   logic                busy;
   logic                done;
   logic                illegal;
   logic [1:0]          t_state;

   modport master (
      output instr_valid, opcode, alu_cf, alu_zf,
      input  instr_ready, nla, nlb, ea, eu, sub, out_strobe,
             cf, zf, busy, done, illegal, t_state
   );

   modport slave (
      input  instr_valid, opcode, alu_cf, alu_zf,
      output instr_ready, nla, nlb, ea, eu, sub, out_strobe,
             cf, zf, busy, done, illegal, t_state
   );
endinterface

// File: rtl/acc_control_sequencer.sv
// Control-word sequencer for the accumulator / B-register / ALU datapath.
// Accepts one opcode per valid/ready handshake and steps T1..T3, each
// T-state lasting HOLD_CYCLES clocks. All control strobes are decoded from
// registered state only, so no input reaches a strobe combinationally.
module acc_control_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned OPCODE_W    = 3
) (
   input logic                     clk,
   input logic                     rst,
   acc_control_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_LDA = 3'b001,
      OP_LDB = 3'b010,
      OP_ADD = 3'b011,
      OP_SUB = 3'b100,
      OP_OUT = 3'b101,
      OP_I6  = 3'b110,
      OP_I7  = 3'b111
   } op_t;

   state_t              state;
   state_t              state_n;
   logic [OPCODE_W-1:0] op_q;
   logic [3:0]          hold_q;
   logic                hold_last;
   logic                accept;
   logic                cf_q;
   logic                zf_q;
   logic                done_q;

   assign hold_last = (hold_q == 4'(HOLD_CYCLES - 1));
   assign accept    = bus.instr_valid & bus.instr_ready;

   // State register; reset aborts any sequence straight to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Dwell counter within a T-state; cleared on every state change and in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 hold_q <= '0;
      else if (state == S_IDLE || state_n != state) hold_q <= '0;
      else                                     hold_q <= hold_q + 4'd1;
   end

   // Opcode latch, loaded only on an accepted handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         op_q <= '0;
      else if (accept) op_q <= bus.opcode;
   end

   // Flags capture at the edge that ends the last cycle of T2, arithmetic ops only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cf_q <= 1'b0;
         zf_q <= 1'b0;
      end else if (state == S_T2 && hold_last &&
                   (op_q == OP_ADD || op_q == OP_SUB)) begin
         cf_q <= bus.alu_cf;
         zf_q <= bus.alu_zf;
      end
   end

   // Completion pulse for the first IDLE cycle after T3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= (state == S_T3) && hold_last;
   end

   // Next-state and microcode decode from registered state/opcode/counter.
   always_comb begin
      state_n         = state;
      bus.instr_ready = 1'b0;
      bus.nla         = 1'b1;
      bus.nlb         = 1'b1;
      bus.ea          = 1'b0;
      bus.eu          = 1'b0;
      bus.sub         = 1'b0;
      bus.out_strobe  = 1'b0;
      bus.illegal     = 1'b0;
      bus.busy        = 1'b0;

      case (state)
         S_IDLE: begin
            bus.instr_ready = ~rst;
            if (bus.instr_valid) state_n = S_T1;
         end
         S_T1: begin
            bus.busy = 1'b1;
            if (hold_last) state_n = S_T2;
            case (op_q)
               OP_LDA: bus.nla = 1'b0;
               OP_LDB: bus.nlb = 1'b0;
               OP_ADD: bus.eu  = 1'b1;
               OP_SUB: begin
                  bus.eu  = 1'b1;
                  bus.sub = 1'b1;
               end
               OP_OUT: begin
                  bus.ea         = 1'b1;
                  bus.out_strobe = 1'b1;
               end
               OP_I6, OP_I7: bus.illegal = (hold_q == 4'd0);
               default: ;
            endcase
         end
         S_T2: begin
            bus.busy = 1'b1;
            if (hold_last) state_n = S_T3;
            case (op_q)
               OP_ADD: begin
                  bus.eu  = 1'b1;
                  bus.nla = 1'b0;
               end
               OP_SUB: begin
                  bus.eu  = 1'b1;
                  bus.sub = 1'b1;
                  bus.nla = 1'b0;
               end
               default: ;
            endcase
         end
         S_T3: begin
            bus.busy = 1'b1;
            if (hold_last) state_n = S_IDLE;
         end
      endcase
   end

   assign bus.cf      = cf_q;
   assign bus.zf      = zf_q;
   assign bus.done    = done_q;
   assign bus.t_state = state;

endmodule

// File: doc/acc_control_sequencer.md
Name: acc_control_sequencer

Overview:
- Control-word generator for the accumulator/B-register/ALU datapath.
- Accepts one opcode per valid/ready handshake and steps a fixed T1..T3 microcode sequence.
- Drives the datapath strobes nla, nlb, ea, eu and sub, and latches the ALU carry/zero flags.
- Replaces manual pin-driven control of the adder-accumulator with a sequenced initiator.

Parameters:
- HOLD_CYCLES, 1, clock cycles each T-state lasts (legal range 1..15).
- OPCODE_W, 3, opcode width (fixed at 3; the microcode below covers 8 codes).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  opcode is presented.
- instr_ready  out  1  sequencer can accept an opcode.
- opcode  in  OPCODE_W  instruction code, sampled on handshake.
- alu_cf  in  1  ALU carry out.
- alu_zf  in  1  ALU zero.
- nla  out  1  active-low load of accumulator A from the bus.
- nlb  out  1  active-low load of register B from the bus.
- ea  out  1  A drives the bus.
- eu  out  1  ALU result drives the bus.
- sub  out  1  ALU subtract select.
- out_strobe  out  1  bus carries a valid output byte.
- cf  out  1  latched carry flag.
- zf  out  1  latched zero flag.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle illegal-opcode pulse.
- t_state  out  2  0=IDLE, 1..3=T1..T3.

Behaviour:
- Reset: state IDLE, opcode register 0, hold counter 0, cf=0, zf=0, done=0, illegal=0.
  - Control outputs go to the inactive word immediately: nla=1, nlb=1, ea=0, eu=0, sub=0, out_strobe=0.
- Control outputs are decoded only from the registered state, opcode and hold counter. There is no combinational path from any input to any control output.
- Handshake:
  - instr_ready=1 only in IDLE and not in reset.
  - Accept when instr_valid & instr_ready at a rising edge; the opcode is latched and the next state is T1.
  - instr_valid outside IDLE is ignored.
- FSM: IDLE -> T1 -> T2 -> T3 -> IDLE.
  - Each T-state lasts HOLD_CYCLES cycles; the hold counter clears on every state change.
  - busy=1 in T1..T3.
- Microcode (signals not listed stay inactive):
  - 000 NOP: no strobes.
  - 001 LDA: T1 nla=0.
  - 010 LDB: T1 nlb=0.
  - 011 ADD: T1 eu=1. T2 eu=1 and nla=0.
  - 100 SUB: T1 eu=1, sub=1. T2 eu=1, sub=1 and nla=0.
  - 101 OUT: T1 ea=1 and out_strobe=1.
  - 110, 111: illegal. illegal=1 for exactly the first cycle of T1; no strobes; the sequence still runs to T3.
- Flags:
  - cf and zf capture alu_cf and alu_zf at the rising edge ending the last cycle of T2, for ADD and SUB only.
  - All other opcodes leave the flags unchanged.
- done: registered, high for exactly the first IDLE cycle after T3.
  - instr_ready is also high in that cycle, so back-to-back issue is allowed.
  - Throughput with HOLD_CYCLES=1 is one instruction per 4 cycles.
- Latency, HOLD_CYCLES=1, handshake at edge k:
  - T1 occupies cycle k+1.
  - T2 occupies cycle k+2.
  - T3 occupies cycle k+3.
  - done is high in cycle k+4.
- Bus-safety invariants, which must hold in every cycle:
  - Never ea=1 together with eu=1.
  - Never nla=0 together with nlb=0.
  - ea=1 only while nla=1.
- Reset mid-sequence: abort immediately to IDLE with the inactive control word. No done pulse, flags cleared, the pending opcode is discarded.
- Simultaneous rst and instr_valid: rst wins and nothing is accepted.

Test Plan:
- Reset, then issue LDA (001) with HOLD_CYCLES=1 -> nla=0 for exactly 1 cycle at k+1; done=1 at k+4; instr_ready low for cycles k+1..k+3.
- Issue ADD with alu_cf=1 and alu_zf=0 held -> eu=1 for 2 cycles, nla=0 in the 2nd of them, then cf=1 and zf=0; a following NOP leaves cf=1 and zf=0.
- Issue SUB with HOLD_CYCLES=3 -> sub=1 and eu=1 for 6 cycles, nla=0 for cycles 4-6; done at k+10.
- Issue opcode 111 -> illegal pulse of 1 cycle, no strobes; an OUT issued back-to-back in the done cycle is accepted and ea=1 with out_strobe=1 one cycle later.
- Assert rst in T2 of ADD -> same cycle: nla=1, eu=0, t_state=0, cf=0; no done pulse; instr_ready=1 once rst deasserts.
- Random opcodes and valid pattern for 10k cycles -> bus-safety invariants hold every cycle and done count equals accepted-handshake count.
